// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-phase decimation clock divider.
package clk_div_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 7;
    localparam int RATIO_OFF  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } ch_state_t;

endpackage

// File: rtl/dec_channel.sv
// One decimation clock channel: start delay, shadowed half-period ratio and
// a 50%-duty output clock with a rising-edge tick.
module dec_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_ratio,
    input  logic [CNT_W-1:0] wr_delay,
    output logic             dec_clk,
    output logic             dec_tick,
    output logic             busy,
    output ch_state_t        state
);

    localparam logic [CNT_W-1:0] OFF = CNT_W'(RATIO_OFF);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dly_cnt;
    logic [CNT_W-1:0] ratio_act;
    logic [CNT_W-1:0] ratio_shd;

    // Priority: sync, then a delayed restart, then a start from IDLE, then
    // the normal (enable-gated) count; a plain ratio write only updates the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dly_cnt   <= '0;
            ratio_act <= '0;
            ratio_shd <= '0;
            dec_clk   <= 1'b0;
            dec_tick  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            dec_tick <= 1'b0;
            if (sync) begin
                cnt       <= '0;
                dly_cnt   <= '0;
                dec_clk   <= 1'b0;
                busy      <= 1'b0;
                ratio_act <= ratio_shd;
                state     <= (ratio_shd != OFF) ? RUN : IDLE;
            end else if (wr && (wr_delay != OFF)) begin
                state     <= DELAY;
                dly_cnt   <= wr_delay;
                ratio_shd <= wr_ratio;
                cnt       <= '0;
                dec_clk   <= 1'b0;
                busy      <= 1'b1;
            end else if (wr && (state == IDLE)) begin
                ratio_shd <= wr_ratio;
                if (wr_ratio != OFF) begin
                    ratio_act <= wr_ratio;
                    cnt       <= '0;
                    state     <= RUN;
                end
            end else begin
                // The shadow write lands after this edge, so a coincident
                // toggle or delay expiry still sees the previous shadow value.
                if (wr) begin
                    ratio_shd <= wr_ratio;
                end
                if (enable) begin
                    case (state)
                        DELAY: begin
                            if (dly_cnt == ONE) begin
                                dly_cnt   <= '0;
                                busy      <= 1'b0;
                                cnt       <= '0;
                                ratio_act <= ratio_shd;
                                state     <= (ratio_shd != OFF) ? RUN : IDLE;
                            end else begin
                                dly_cnt <= dly_cnt - ONE;
                            end
                        end
                        RUN: begin
                            if (cnt == ratio_act - ONE) begin
                                cnt       <= '0;
                                ratio_act <= ratio_shd;
                                if (ratio_shd == OFF) begin
                                    state   <= IDLE;
                                    dec_clk <= 1'b0;
                                end else begin
                                    dec_clk  <= ~dec_clk;
                                    dec_tick <= ~dec_clk;
                                end
                            end else begin
                                cnt <= cnt + ONE;
                            end
                        end
                        default: begin
                            dec_clk <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/multi_phase_clock_divider.sv
// N-channel decimation clock divider: configuration decode, cfg_ready and
// sync fan-out around an array of dec_channel instances.
module multi_phase_clock_divider
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                sync_all,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_ratio,
    input  logic [CNT_W-1:0]    cfg_delay,
    output logic [NUM_CH-1:0]   dec_clk,
    output logic [NUM_CH-1:0]   dec_tick,
    output logic [NUM_CH-1:0]   busy,
    output logic [2*NUM_CH-1:0] dbg_state
);

    // Handshake: a write is taken on an edge where cfg_valid && cfg_ready;
    // cfg_ready is low in the first cycle after reset and whenever sync_all is high.
    logic ready_q;
    logic accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign cfg_ready = ready_q & ~sync_all;
    assign accept    = cfg_valid & cfg_ready;

    // Channel numbers at or above NUM_CH match no instance and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic      wr;
        ch_state_t st;

        assign wr = accept && (cfg_ch == CH_W'(i));

        dec_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .enable  (enable),
            .sync    (sync_all),
            .wr      (wr),
            .wr_ratio(cfg_ratio),
            .wr_delay(cfg_delay),
            .dec_clk (dec_clk[i]),
            .dec_tick(dec_tick[i]),
            .busy    (busy[i]),
            .state   (st)
        );

        assign dbg_state[2*i +: 2] = st;
    end

endmodule

// File: tb/tb_multi_phase_clock_divider.sv
// Self-checking bench: per-cycle expected-output scoreboard for waveform
// scenarios plus a table of single-cycle configuration vectors.
module tb_multi_phase_clock_divider;

  localparam int NCH = 3;
  localparam int CW  = 7;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable;
  logic           sync_all;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_ratio;
  logic [CW-1:0]  cfg_delay;
  logic [NCH-1:0] dec_clk;
  logic [NCH-1:0] dec_tick;
  logic [NCH-1:0] busy;
  logic [2*NCH-1:0] dbg_state;
  logic [3*NCH-1:0] obs;

  int n_cmp = 0;
  int n_fail = 0;
  logic [3*NCH-1:0] exp_q[$];
  logic [2:0] ec, et, eb;

  typedef struct {
    logic       sync;
    logic       valid;
    logic [1:0] ch;
    logic [6:0] ratio;
    logic [6:0] delay;
    logic       exp_ready;
    logic [2:0] c;
    logic [2:0] t;
    logic [2:0] b;
  } vec_t;

  vec_t vecs[12];

  multi_phase_clock_divider #(.NUM_CH(NCH), .CNT_W(CW), .CH_W(CHW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .sync_all (sync_all),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_ratio(cfg_ratio),
    .cfg_delay(cfg_delay),
    .dec_clk  (dec_clk),
    .dec_tick (dec_tick),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  assign obs = {dec_clk, dec_tick, busy};

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cfg_valid = 1'b0;
    sync_all  = 1'b0;
    cfg_ch    = '0;
    cfg_ratio = '0;
    cfg_delay = '0;
  endtask

  task automatic wr(input int ch, input int r, input int d);
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_ratio = CW'(r);
    cfg_delay = CW'(d);
  endtask

  task automatic do_reset();
    idle_in();
    enable = 1'b1;
    rst_n  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard
  task automatic push_exp(input logic [2:0] c, input logic [2:0] t, input logic [2:0] b);
    exp_q.push_back({c, t, b});
  endtask

  task automatic sb_check(input string name);
    logic [3*NCH-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", name, obs);
    end else begin
      e = exp_q.pop_front();
      check(name, 16'(obs), 16'(e));
    end
  endtask

  initial begin
    // {sync, valid, ch, ratio, delay, exp_ready, clk, tick, busy}
    vecs[0]  = '{1'b0, 1'b1, 2'd3, 7'd2, 7'd0, 1'b1, 3'b000, 3'b000, 3'b000};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 7'd0, 7'd5, 1'b1, 3'b000, 3'b000, 3'b001};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 7'd0, 7'd0, 1'b0, 3'b000, 3'b000, 3'b000};
    vecs[3]  = '{1'b1, 1'b1, 2'd1, 7'd1, 7'd3, 1'b0, 3'b000, 3'b000, 3'b000};
    vecs[4]  = '{1'b0, 1'b1, 2'd1, 7'd1, 7'd1, 1'b1, 3'b000, 3'b000, 3'b010};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 7'd0, 7'd0, 1'b1, 3'b000, 3'b000, 3'b000};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 7'd0, 7'd0, 1'b1, 3'b010, 3'b010, 3'b000};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 7'd0, 7'd0, 1'b1, 3'b000, 3'b000, 3'b000};
    vecs[8]  = '{1'b0, 1'b1, 2'd2, 7'd0, 7'd0, 1'b1, 3'b010, 3'b010, 3'b000};
    vecs[9]  = '{1'b0, 1'b1, 2'd1, 7'd0, 7'd0, 1'b1, 3'b000, 3'b000, 3'b000};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 7'd0, 7'd0, 1'b1, 3'b000, 3'b000, 3'b000};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 7'd0, 7'd0, 1'b1, 3'b000, 3'b000, 3'b000};

    // reset state
    idle_in();
    enable = 1'b1;
    rst_n  = 1'b0;
    step();
    step();
    check("reset_outputs", 16'(obs), 16'd0);
    check("reset_ready", 16'(cfg_ready), 16'd0);
    check("reset_state", 16'(dbg_state), 16'd0);
    rst_n = 1'b1;
    #2;
    check("ready_before_edge", 16'(cfg_ready), 16'd0);
    step();
    check("ready_after_edge", 16'(cfg_ready), 16'd1);

    // A: ch0 ratio 3, no delay -> period 6
    wr(0, 3, 0);
    for (int k = 0; k < 24; k++) begin
      ec = '0; et = '0; eb = '0;
      ec[0] = ((k / 3) % 2) == 1;
      et[0] = (k % 6) == 3;
      push_exp(ec, et, eb);
    end
    for (int k = 0; k < 24; k++) begin
      step();
      if (k == 0) idle_in();
      sb_check("A_ratio3");
    end

    // B: two channels, sync, then delayed restart of ch1
    do_reset();
    wr(0, 4, 0);
    step();
    idle_in();
    check("B_ch0_start", 16'(obs), 16'd0);
    wr(1, 4, 2);
    step();
    idle_in();
    check("B_ch1_delay", 16'(obs), 16'({3'b000, 3'b000, 3'b010}));
    sync_all = 1'b1;
    #1;
    check("B_ready_sync", 16'(cfg_ready), 16'd0);
    for (int j = 0; j < 24; j++) begin
      ec = '0; et = '0; eb = '0;
      ec[0] = ((j / 4) % 2) == 1;
      et[0] = (j % 8) == 4;
      eb[1] = (j == 1) || (j == 2);
      if (j >= 3) begin
        ec[1] = (((j - 3) / 4) % 2) == 1;
        et[1] = ((j - 3) % 8) == 4;
      end
      push_exp(ec, et, eb);
    end
    for (int j = 0; j < 24; j++) begin
      step();
      if (j == 0) begin
        sync_all = 1'b0;
        wr(1, 4, 2);
      end
      if (j == 1) idle_in();
      sb_check("B_sync_stagger");
    end

    // C: ratio 5 -> 2 written mid half-period
    do_reset();
    wr(2, 5, 0);
    for (int k = 0; k < 24; k++) begin
      ec = '0; et = '0; eb = '0;
      if (k < 10) ec[2] = (k >= 5);
      else        ec[2] = (((k - 10) / 2) % 2) == 1;
      et[2] = (k == 5) || ((k >= 10) && ((k - 10) % 4) == 2);
      push_exp(ec, et, eb);
    end
    for (int k = 0; k < 24; k++) begin
      step();
      if (k == 0) idle_in();
      if (k == 6) wr(2, 2, 0);
      if (k == 7) idle_in();
      sb_check("C_shadow_ratio");
    end

    // D: ratio 0 written while high -> low at next toggle, then stays off
    do_reset();
    wr(1, 3, 0);
    for (int k = 0; k < 20; k++) begin
      ec = '0; et = '0; eb = '0;
      ec[1] = (k >= 3) && (k < 6);
      et[1] = (k == 3);
      push_exp(ec, et, eb);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 0) idle_in();
      if (k == 3) wr(1, 0, 0);
      if (k == 4) idle_in();
      sb_check("D_ratio_off");
    end

    // E: sync beats a write; enable low for 10 cycles with a write inside
    do_reset();
    wr(0, 3, 0);
    step();
    idle_in();
    step();
    sync_all = 1'b1;
    wr(1, 2, 0);
    #1;
    check("E_ready_sync", 16'(cfg_ready), 16'd0);
    for (int j = 0; j < 30; j++) begin
      int e, m;
      ec = '0; et = '0; eb = '0;
      e = (j < 5) ? j : ((j < 15) ? 4 : j - 10);
      ec[0] = ((e / 3) % 2) == 1;
      et[0] = ((j < 5) || (j >= 15)) && ((e % 6) == 3);
      m = (j < 15) ? 0 : j - 14;
      ec[1] = (m > 0) && (((m / 2) % 2) == 1);
      et[1] = (m > 0) && ((m % 4) == 2);
      push_exp(ec, et, eb);
    end
    for (int j = 0; j < 30; j++) begin
      step();
      if (j == 0) idle_in();
      if (j == 4) enable = 1'b0;
      if (j == 6) wr(1, 2, 0);
      if (j == 7) idle_in();
      if (j == 14) enable = 1'b1;
      sb_check("E_freeze");
    end

    // F: asynchronous reset mid-RUN and mid-DELAY
    do_reset();
    wr(0, 2, 0);
    step();
    wr(1, 3, 20);
    step();
    idle_in();
    step();
    check("F_before_reset", 16'(obs), 16'({3'b001, 3'b001, 3'b010}));
    #2;
    rst_n = 1'b0;
    #1;
    check("F_async_outputs", 16'(obs), 16'd0);
    check("F_async_ready", 16'(cfg_ready), 16'd0);
    check("F_async_state", 16'(dbg_state), 16'd0);
    step();
    step();
    rst_n = 1'b1;
    #2;
    check("F_ready_held", 16'(cfg_ready), 16'd0);
    step();
    check("F_ready_rise", 16'(cfg_ready), 16'd1);

    // table-driven single-cycle vectors (channel 3 does not exist)
    for (int i = 0; i < 12; i++) begin
      sync_all  = vecs[i].sync;
      cfg_valid = vecs[i].valid;
      cfg_ch    = vecs[i].ch;
      cfg_ratio = vecs[i].ratio;
      cfg_delay = vecs[i].delay;
      #1;
      check($sformatf("T%0d_ready", i), 16'(cfg_ready), 16'(vecs[i].exp_ready));
      step();
      check($sformatf("T%0d_out", i), 16'(obs), 16'({vecs[i].c, vecs[i].t, vecs[i].b}));
      idle_in();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
